// File: rtl/fifo_bus_master_if.sv
// Bus bundle between the FIFO drain stage and its neighbours.
//   fifo_data  : FIFO registered read data, {addr, wdata}
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : FIFO read strobe, one cycle per word
//   bus_addr   : register write address
//   bus_wdata  : register write data
//   bus_valid  : write request
//   bus_ready  : write accepted when high together with bus_valid
// The master modport is the drain stage; the slave modport is the FIFO plus register bus.
interface fifo_bus_master_if #(
  parameter int unsigned DATA_WIDTH = 22,
  parameter int unsigned ADDR_BITS  = 6
);
  logic [DATA_WIDTH-1:0]           fifo_data;
  logic                            fifo_empty;
  logic                            fifo_rd_en;
  logic [ADDR_BITS-1:0]            bus_addr;
  logic [DATA_WIDTH-ADDR_BITS-1:0] bus_wdata;
  logic                            bus_valid;
  logic                            bus_ready;

  modport master (
    input  fifo_data, fifo_empty, bus_ready,
    output fifo_rd_en, bus_addr, bus_wdata, bus_valid
  );

  modport slave (
    output fifo_data, fifo_empty, bus_ready,
    input  fifo_rd_en, bus_addr, bus_wdata, bus_valid
  );
endinterface

// File: rtl/fifo_bus_master.sv
// FIFO drain stage: pops one entry at a time, splits it into {addr, wdata} and issues it as a
// single write on a valid/ready bus. A word the bus never accepts is dropped after TIMEOUT
// cycles of bus_valid.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   enable      : permits new pops; only looked at when no word is in flight
//   io          : FIFO read side and register bus (master modport)
//   busy        : high whenever the FSM is not idle
//   timeout_err : one-cycle pulse in the first idle cycle after a dropped word
//   xfer_count  : accepted writes, wrapping
//   err_count   : dropped words, saturating at 255
module fifo_bus_master #(
  parameter int unsigned DATA_WIDTH = 22,
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  fifo_bus_master_if.master      io,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            xfer_count,
  output logic [7:0]             err_count
);

  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned WdataW = DATA_WIDTH - ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StPop, StCapt, StReq} state_e;

  state_e                state_q, state_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [WdataW-1:0]     wdata_q, wdata_d;
  logic [15:0]           xfer_q, xfer_d;
  logic [7:0]            err_q, err_d;
  logic                  terr_q, terr_d;
  logic                  start;

  // Only one read is ever outstanding, so fifo_empty is current whenever it is sampled here.
  assign start = enable && !io.fifo_empty;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    xfer_d  = xfer_q;
    err_d   = err_q;
    terr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StPop;
      end
      StPop: begin
        state_d = StCapt;
      end
      StCapt: begin
        // FIFO data_out was updated at the end of the pop cycle.
        addr_d  = io.fifo_data[DATA_WIDTH-1 -: ADDR_BITS];
        wdata_d = io.fifo_data[WdataW-1:0];
        wait_d  = '0;
        state_d = StReq;
      end
      StReq: begin
        if (io.bus_ready) begin
          // Acceptance wins even on the last allowed cycle.
          xfer_d  = xfer_q + 16'd1;
          state_d = start ? StPop : StIdle;
        end else begin
          if (wait_q != WaitW'(TIMEOUT)) wait_d = wait_q + WaitW'(1);
          // wait_q holds the number of earlier stalled cycles, so this is the TIMEOUT-th.
          if (wait_q == WaitW'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            state_d = StIdle;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      xfer_q  <= '0;
      err_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      xfer_q  <= xfer_d;
      err_q   <= err_d;
      terr_q  <= terr_d;
    end
  end

  // Outputs are decoded from registered state so reset clears them immediately.
  assign io.fifo_rd_en = (state_q == StPop);
  assign io.bus_valid  = (state_q == StReq);
  assign io.bus_addr   = addr_q;
  assign io.bus_wdata  = wdata_q;
  assign busy          = (state_q != StIdle);
  assign timeout_err   = terr_q;
  assign xfer_count    = xfer_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_fifo_bus_master.sv
// Directed bench for fifo_bus_master: a vector table of single-word transfers with varying
// bus back-pressure, plus hand-written sequences for timeout recovery, bursts, enable drop,
// asynchronous reset and error-counter saturation.
module tb_fifo_bus_master;
  localparam int unsigned DW = 22;
  localparam int unsigned AW = 6;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [15:0] xfer_count;
  logic [7:0]  err_count;

  fifo_bus_master_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) io ();

  fifo_bus_master #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .io(io),
    .busy(busy),
    .timeout_err(timeout_err),
    .xfer_count(xfer_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered data_out, updated at the end of a read-strobe cycle.
  logic [DW-1:0] fifo_mem [1024];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] fifo_dout = '0;
  assign io.fifo_data  = fifo_dout;
  assign io.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (io.fifo_rd_en && rd_ptr != wr_ptr) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [15:0] d);
    fifo_mem[wr_ptr] = {a, d};
    wr_ptr = wr_ptr + 1;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    int          ready_delay;  // stalled REQ cycles before ready; -1 = never ready
    int          exp_valid;
    int          exp_acc;
    int          exp_terr;
  } vec_t;

  vec_t vecs [6];

  int          exp_xfer;
  int          exp_err;
  int          vc, rd, terr, acc, k, bad, last_rd, gaps_bad;
  bit          stable, seen;
  logic [5:0]  sa;
  logic [15:0] sd;
  logic [DW-1:0] ent;

  initial begin
    vecs[0] = '{6'h0A, 16'h1234,  0,  1, 1, 0};
    vecs[1] = '{6'h3F, 16'hFFFF,  5,  6, 1, 0};
    vecs[2] = '{6'h01, 16'hA5A5, -1, 16, 0, 1};
    vecs[3] = '{6'h15, 16'h5555, 15, 16, 1, 0};
    vecs[4] = '{6'h00, 16'h0000, 14, 15, 1, 0};
    vecs[5] = '{6'h2A, 16'hBEEF,  1,  2, 1, 0};

    io.bus_ready = 1'b0;
    exp_xfer = 0;
    exp_err  = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", io.bus_valid, 0);
    check("rst_rd_en", io.fifo_rd_en, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_xfer", xfer_count, 0);
    check("rst_err", err_count, 0);
    check("rst_addr", io.bus_addr, 0);
    check("rst_wdata", io.bus_wdata, 0);
    rst = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Table-driven single-word transfers
    for (int v = 0; v < 6; v++) begin
      io.bus_ready = 1'b0;
      vc = 0; rd = 0; terr = 0; stable = 1; sa = '0; sd = '0;
      push(vecs[v].addr, vecs[v].data);
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (io.fifo_rd_en) rd++;
        if (timeout_err) terr++;
        if (io.bus_valid) begin
          vc++;
          if (vc == 1) begin
            sa = io.bus_addr;
            sd = io.bus_wdata;
          end else if (io.bus_addr !== sa || io.bus_wdata !== sd) begin
            stable = 0;
          end
          io.bus_ready = (vecs[v].ready_delay >= 0 && vc > vecs[v].ready_delay);
        end else begin
          io.bus_ready = 1'b0;
        end
      end
      exp_xfer += vecs[v].exp_acc;
      exp_err  += vecs[v].exp_terr;
      check($sformatf("v%0d_valid_cycles", v), vc, vecs[v].exp_valid);
      check($sformatf("v%0d_addr", v), sa, vecs[v].addr);
      check($sformatf("v%0d_wdata", v), sd, vecs[v].data);
      check($sformatf("v%0d_stable", v), stable, 1);
      check($sformatf("v%0d_rd_pulses", v), rd, 1);
      check($sformatf("v%0d_terr_pulses", v), terr, vecs[v].exp_terr);
      check($sformatf("v%0d_xfer", v), xfer_count, exp_xfer);
      check($sformatf("v%0d_err", v), err_count, exp_err);
      check($sformatf("v%0d_busy_end", v), busy, 0);
    end

    // Timeout then a second queued word pops normally
    io.bus_ready = 1'b0;
    push(6'h11, 16'h1111);
    push(6'h22, 16'h2222);
    vc = 0; seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (io.bus_valid) vc++;
      if (timeout_err) seen = 1;
    end
    exp_err++;
    check("to_seen", seen, 1);
    check("to_valid_cycles", vc, TO);
    check("to_err", err_count, exp_err);
    io.bus_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (io.bus_valid) seen = 1;
    end
    check("to2_valid_seen", seen, 1);
    check("to2_addr", io.bus_addr, 6'h22);
    check("to2_wdata", io.bus_wdata, 16'h2222);
    @(negedge clk);
    exp_xfer++;
    check("to2_xfer", xfer_count, exp_xfer);
    check("to2_busy", busy, 0);
    check("to2_fifo_empty", io.fifo_empty, 1);

    // Burst of 14 with ready held high
    io.bus_ready = 1'b1;
    for (int i = 0; i < 14; i++) push(6'(i + 1), 16'h1000 + 16'(i * 16'h0111));
    rd = 0; k = 0; bad = 0; last_rd = -1; gaps_bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (io.fifo_rd_en) begin
        if (last_rd >= 0 && c - last_rd != 3) gaps_bad++;
        last_rd = c;
        rd++;
      end
      if (io.bus_valid) begin
        ent = {6'(k + 1), 16'h1000 + 16'(k * 16'h0111)};
        if ({io.bus_addr, io.bus_wdata} !== ent) bad++;
        k++;
      end
    end
    exp_xfer += 14;
    check("burst_rd_pulses", rd, 14);
    check("burst_gaps", gaps_bad, 0);
    check("burst_words", k, 14);
    check("burst_data_order", bad, 0);
    check("burst_xfer", xfer_count, exp_xfer);
    check("burst_fifo_empty", io.fifo_empty, 1);

    // Enable dropped during REQ
    io.bus_ready = 1'b0;
    push(6'h33, 16'h3333);
    push(6'h34, 16'h3434);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (io.bus_valid) seen = 1;
    end
    check("en_valid_seen", seen, 1);
    enable = 1'b0;
    @(negedge clk);
    io.bus_ready = 1'b1;
    rd = 0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (io.fifo_rd_en) rd++;
      if (io.bus_valid) acc++;
    end
    exp_xfer++;
    check("en_no_more_pops", rd, 0);
    check("en_xfer", xfer_count, exp_xfer);
    check("en_fifo_left", wr_ptr - rd_ptr, 1);
    check("en_busy", busy, 0);

    // Asynchronous reset mid-REQ
    io.bus_ready = 1'b0;
    enable = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (io.bus_valid) seen = 1;
    end
    check("rst2_valid_seen", seen, 1);
    rst = 1'b0;
    #1;
    check("rst2_valid", io.bus_valid, 0);
    check("rst2_xfer", xfer_count, 0);
    check("rst2_err", err_count, 0);
    check("rst2_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_xfer = 0;
    exp_err  = 0;

    // Error counter saturation: 300 forced timeouts
    io.bus_ready = 1'b0;
    for (int i = 0; i < 300; i++) push(6'(i), 16'(i));
    terr = 0;
    for (int c = 0; c < 8000 && terr < 300; c++) begin
      @(negedge clk);
      if (timeout_err) begin
        terr++;
        if (terr == 100) check("sat_err_100", err_count, 100);
      end
    end
    @(negedge clk);
    check("sat_pulses", terr, 300);
    check("sat_err", err_count, 255);
    check("sat_xfer", xfer_count, 0);
    check("sat_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_bus_master.md
# fifo_bus_master

Downstream drain stage for the 22-bit sync FIFO. It pops one entry at a time, splits each entry into a 6-bit address and 16-bit write data, and issues it as a single write on a valid/ready register bus. A per-transfer timeout drops words the bus never accepts, and transfer and error counters are kept for status readback.

## Interface
- DATA_WIDTH, 22: FIFO entry width. Entry format is {addr, wdata}.
- ADDR_BITS, 6: address field, taken from entry bits [DATA_WIDTH-1 -: ADDR_BITS].
- TIMEOUT, 16: maximum number of cycles `bus_valid` is held without `bus_ready` before the word is dropped. Legal range is ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting new pops. Sampled only when no word is in flight.
- fifo_data  in  DATA_WIDTH  FIFO registered `data_out`.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe, exactly one cycle per word.
- bus_addr  out  ADDR_BITS  write address.
- bus_wdata  out  DATA_WIDTH-ADDR_BITS  write data.
- bus_valid  out  1  write request.
- bus_ready  in  1  bus accepts the write on a cycle where `bus_valid` and `bus_ready` are both 1.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when a word is dropped.
- xfer_count  out  16  count of accepted writes. Wraps from 0xFFFF to 0.
- err_count  out  8  count of dropped words. Saturates at 255.

## Operation
- FSM states are IDLE, POP, CAPT and REQ.
- **IDLE:** moves to POP when `enable` is 1 and `fifo_empty` is 0. Otherwise it stays in IDLE.
- **POP:** drives `fifo_rd_en` = 1 for this single cycle. The FIFO updates `data_out` at the end of this cycle. Always moves to CAPT.
- **CAPT:** `bus_addr` and `bus_wdata` load from `fifo_data` at the end of this cycle. The wait counter clears to 0. Always moves to REQ.
- **REQ, outputs:** `bus_valid` = 1. `bus_addr` and `bus_wdata` stay stable until the word leaves REQ.
  - The wait counter increments on each cycle of REQ in which `bus_ready` is 0.
- **REQ, on acceptance** (`bus_ready` = 1):
  - `xfer_count` increments.
  - If `enable` is 1 and `fifo_empty` is 0, the next state is POP (back-to-back transfers). Otherwise it is IDLE.
- **REQ, on timeout:** happens when `bus_ready` = 0 and this is the TIMEOUT-th cycle in REQ.
  - The word is discarded and `timeout_err` pulses on the next cycle.
  - `err_count` increments, saturating at 255.
  - The next state is IDLE.
- **Priority:** `bus_ready` on the TIMEOUT-th cycle counts as acceptance, not a timeout.
- **One outstanding read:** at most one FIFO read is outstanding at any time. Because of this, `fifo_empty` is always current when sampled in IDLE or REQ.
- **`enable` deasserted mid-word:** the in-flight word still completes or times out. No further pops occur.
- **Wait counter:** width is $clog2(TIMEOUT+1). It never wraps; it holds at TIMEOUT.

## Timing
- **Reset:** asserting `rst` low forces, immediately and asynchronously:
  - state = IDLE;
  - `fifo_rd_en`, `bus_valid`, `busy` and `timeout_err` = 0;
  - `bus_addr`, `bus_wdata`, `xfer_count`, `err_count` and the wait counter = 0.
- **Reset mid-transfer:** a word in POP, CAPT or REQ is lost and `bus_valid` drops at once. Release of `rst` is synchronous to `clk`.
- **Start latency:** if IDLE samples `enable` = 1 and `fifo_empty` = 0 at edge E0:
  - `fifo_rd_en` is high during E0→E1;
  - `bus_valid` is first high during E2→E3.
- **Back-to-back throughput:** one word per 3 cycles when `bus_ready` is always high (POP, CAPT, REQ).
- **`busy`:** registered with the state. It is 1 for the whole of POP, CAPT and REQ.
- **`timeout_err`:** high for exactly one cycle, the first cycle back in IDLE.

## Test plan
- **Single word:** FIFO holds 0x0A_1234 (addr 0x0A, data 0x1234), `enable` = 1, `bus_ready` = 1 → one `fifo_rd_en` pulse; `bus_valid` for 1 cycle with `bus_addr` = 0x0A and `bus_wdata` = 0x1234; `xfer_count` = 1; returns to IDLE with `busy` = 0.
- **Back-pressure:** `bus_ready` held low for 5 cycles in REQ, then high → `bus_valid` high for 6 cycles with address and data stable; `xfer_count` = 1; `err_count` = 0.
- **Timeout:** `bus_ready` never asserted, TIMEOUT = 16 → `bus_valid` high for exactly 16 cycles; one `timeout_err` pulse; `err_count` = 1; a second queued word then pops normally. `bus_ready` asserted on cycle 16 instead → accepted, `err_count` = 0.
- **Burst:** 14 entries queued, `bus_ready` = 1 → 14 `fifo_rd_en` pulses spaced exactly 3 cycles apart; data arrives in order; `xfer_count` = 14; FIFO ends empty.
- **`enable` and reset:**
  - `enable` dropped during REQ → the current word completes and no further `fifo_rd_en` occurs.
  - `rst` pulsed low mid-REQ → `bus_valid`, `xfer_count` and `err_count` read 0 before the next clock edge.
- **Saturation:** 300 forced timeouts → `err_count` stops at 255.
